// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT definitions.
//   agen_state_e : address-generator FSM states (IDLE, RUN, DRAIN, DONE)
//   LOGN_DEF     : default log2 transform size
//   Q            : coefficient modulus (65537)
//   N_BITS       : coefficient width shared with butterfly / modular arithmetic
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } agen_state_e;

    localparam int LOGN_DEF = 8;
    localparam int Q        = 65537;
    localparam int N_BITS   = 17;

endpackage

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: reset-clearable shift register, DEPTH stages of W bits.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  async active-low reset, clears every stage
//   din   in  W  value entering the line
//   dout  out W  din delayed by DEPTH cycles
module ntt_delay_line #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] taps [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: radix-2 DIT in-place NTT address sequencer.
// Issues one butterfly per RUN cycle (rd_addr0/rd_addr1 + tf_addr), drains
// LAT = RD_LAT+BF_LAT cycles between stages, and emits write-back addresses
// delayed by LAT so they line up with the butterfly outputs.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                one-cycle request, honoured only in IDLE
//   hold                 (only with NTT_AGEN_HOLD_EN) stalls issue while in RUN
//   busy                 high from accept through the last wr_en
//   done                 one-cycle pulse after the final wr_en
//   stage                current stage index
//   rd_en, rd_addr0/1    read strobe and butterfly operand addresses
//   tf_addr              twiddle ROM index
//   wr_en, wr_addr0/1    read strobe/addresses delayed by LAT
// Optional feature macro: NTT_AGEN_HOLD_EN
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOGN   = LOGN_DEF,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1,
    localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef NTT_AGEN_HOLD_EN
    input  logic            hold,
`endif
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-2:0] tf_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1
);

    localparam int LAT = RD_LAT + BF_LAT;
    localparam int JW  = LOGN - 1;
    localparam int DW  = $clog2(LAT + 1);

    localparam logic [JW-1:0]   J_LAST = '1;
    localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
    localparam logic [DW-1:0]   D_LAST = DW'(LAT - 1);
    localparam logic [LOGN-1:0] ONE    = LOGN'(1);

    agen_state_e   state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [JW-1:0] j_q, j_d;
    logic [DW-1:0] d_q, d_d;
    logic          stall;
    logic          issue;

`ifdef NTT_AGEN_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    assign issue = (state_q == RUN) && !stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            d_q     <= d_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    // j wraps to 0 on the last butterfly, ready for the next stage
                    j_d = j_q + JW'(1);
                    if (j_q == J_LAST) begin
                        state_d = DRAIN;
                        d_d     = '0;
                    end
                end
            end
            DRAIN: begin
                if (d_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                        j_d     = '0;
                    end
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterfly address math from the current (s, j)
    logic [LOGN-1:0] jx, half, k, grp, a0, a1;
    logic [LOGN-2:0] tf;

    always_comb begin
        jx   = {1'b0, j_q};
        half = ONE << s_q;
        k    = jx & (half - ONE);
        grp  = jx >> s_q;
        a0   = ((grp << s_q) << 1) | k;
        a1   = a0 | half;
        tf   = JW'(k << (LOGN - 1 - s_q));
    end

    // Outputs; addresses are forced to zero outside RUN so idle/reset reads 0,
    // while a held RUN cycle keeps presenting the pending butterfly.
    always_comb begin
        rd_en    = issue;
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == DONE);
        stage    = s_q;
        rd_addr0 = (state_q == RUN) ? a0 : '0;
        rd_addr1 = (state_q == RUN) ? a1 : '0;
        tf_addr  = (state_q == RUN) ? tf : '0;
    end

    logic [2*LOGN:0] wr_bus;

    ntt_delay_line #(
        .W     (2 * LOGN + 1),
        .DEPTH (LAT)
    ) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({rd_en, rd_addr0, rd_addr1}),
        .dout  (wr_bus)
    );

    assign {wr_en, wr_addr0, wr_addr1} = wr_bus;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: bench for ntt_addr_gen at LOGN=3, RD_LAT=1, BF_LAT=1.
// Expected per-cycle outputs come from a schedule built from the transform's
// butterfly ordering; hold scenarios only when NTT_AGEN_HOLD_EN is defined.
module tb_ntt_addr_gen;

    localparam int LOGN = 3;
    localparam int LAT  = 2;
    localparam int N    = 8;
    localparam int H    = 4;
    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
`ifdef NTT_AGEN_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [1:0] tf_addr;

    always #5 clk = ~clk;

    ntt_addr_gen #(
        .LOGN   (3),
        .RD_LAT (1),
        .BF_LAT (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef NTT_AGEN_HOLD_EN
        .hold     (hold),
`endif
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tf_addr  (tf_addr),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int done_at;

    bit e_rd[MAXC], e_wr[MAXC], e_done[MAXC], e_busy[MAXC], e_zero[MAXC];
    int e_stage[MAXC], e_a0[MAXC], e_a1[MAXC], e_tf[MAXC], e_w0[MAXC], e_w1[MAXC];
    bit st_v[MAXC], rs_v[MAXC], hold_v[MAXC];
    int iss_a0[$], iss_a1[$], iss_tf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_wr[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_zero[i] = 0;
            e_stage[i] = 0; e_a0[i] = 0; e_a1[i] = 0; e_tf[i] = 0; e_w0[i] = 0; e_w1[i] = 0;
            st_v[i] = 0; rs_v[i] = 0; hold_v[i] = 0;
        end
        iss_a0.delete(); iss_a1.delete(); iss_tf.delete();
    endtask

    // Transform accepted at cycle c0: stage by stage, butterfly j pairs
    // elements j%half and j%half+half inside group j/half; stalls push issues later.
    task automatic schedule(input int c0);
        int t, half, a0, a1, tf;
        t = c0 + 1;
        for (int s = 0; s < LOGN; s++) begin
            half = 1 << s;
            for (int j = 0; j < H; j++) begin
                while (hold_v[t]) begin
                    e_busy[t] = 1; e_stage[t] = s; t++;
                end
                a0 = (j / half) * 2 * half + (j % half);
                a1 = a0 + half;
                tf = (j % half) * (N / (2 * half));
                e_rd[t] = 1; e_busy[t] = 1; e_stage[t] = s;
                e_a0[t] = a0; e_a1[t] = a1; e_tf[t] = tf;
                e_wr[t+LAT] = 1; e_w0[t+LAT] = a0; e_w1[t+LAT] = a1;
                iss_a0.push_back(a0); iss_a1.push_back(a1); iss_tf.push_back(tf);
                t++;
            end
            for (int d = 0; d < LAT; d++) begin
                e_busy[t] = 1; e_stage[t] = s; t++;
            end
        end
        e_done[t] = 1;
        done_at = t;
    endtask

    // Reset held over cycles [r, rel): everything scheduled from r on is dropped.
    task automatic zero_from(input int r, input int rel);
        for (int i = r; i < MAXC; i++) begin
            e_rd[i] = 0; e_wr[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_stage[i] = 0; e_a0[i] = 0; e_a1[i] = 0; e_tf[i] = 0; e_w0[i] = 0; e_w1[i] = 0;
        end
        for (int i = r; i < rel; i++) begin
            e_zero[i] = 1; rs_v[i] = 1;
        end
    endtask

    task automatic run(input int ncyc);
        chk_en = 0; start = 0; rst_n = 0;
`ifdef NTT_AGEN_HOLD_EN
        hold = 0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        cyc = 0;
        chk_en = 1;
        for (int c = 0; c < ncyc; c++) begin
            start = st_v[c];
            rst_n = !rs_v[c];
`ifdef NTT_AGEN_HOLD_EN
            hold = hold_v[c];
`endif
            @(posedge clk); #1;
            cyc++;
        end
        chk_en = 0;
        start = 0;
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("rd_en", rd_en, e_rd[cyc]);
            check("wr_en", wr_en, e_wr[cyc]);
            check("done",  done,  e_done[cyc]);
            check("busy",  busy,  e_busy[cyc]);
            if (e_busy[cyc]) check("stage", stage, e_stage[cyc]);
            if (e_rd[cyc]) begin
                check("rd_addr0", rd_addr0, e_a0[cyc]);
                check("rd_addr1", rd_addr1, e_a1[cyc]);
                check("tf_addr",  tf_addr,  e_tf[cyc]);
            end
            if (e_wr[cyc]) begin
                check("wr_addr0", wr_addr0, e_w0[cyc]);
                check("wr_addr1", wr_addr1, e_w1[cyc]);
            end
            if (e_zero[cyc]) begin
                check("rst_stage", stage,    0);
                check("rst_a0",    rd_addr0, 0);
                check("rst_a1",    rd_addr1, 0);
                check("rst_tf",    tf_addr,  0);
                check("rst_w0",    wr_addr0, 0);
                check("rst_w1",    wr_addr1, 0);
            end
        end
    end

    int lit_rd [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    int lit_wr [12] = '{3, 4, 5, 6, 9, 10, 11, 12, 15, 16, 17, 18};
    int lit_a0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_a1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tf [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    initial begin
        int nrd, nbusy;

        // Basic run: pin the model against hand-computed timing and addresses
        clear_model();
        st_v[0] = 1;
        schedule(0);
        nrd = 0; nbusy = 0;
        for (int i = 0; i < MAXC; i++) begin
            nrd   += int'(e_rd[i]);
            nbusy += int'(e_busy[i]);
        end
        check("pin_nrd", nrd, 12);
        check("pin_nbusy", nbusy, 18);
        check("pin_busy1", e_busy[1], 1);
        check("pin_busy19", e_busy[19], 0);
        check("pin_done_at", done_at, 19);
        for (int i = 0; i < 12; i++) begin
            check("pin_rd", e_rd[lit_rd[i]], 1);
            check("pin_wr", e_wr[lit_wr[i]], 1);
            check("pin_a0", iss_a0[i], lit_a0[i]);
            check("pin_a1", iss_a1[i], lit_a1[i]);
            check("pin_tf", iss_tf[i], lit_tf[i]);
        end
        run(24);

        // Starts while busy are ignored
        clear_model();
        st_v[0] = 1; st_v[5] = 1; st_v[12] = 1;
        schedule(0);
        run(24);

        // Reset mid-run, then a fresh start
        clear_model();
        st_v[0] = 1;
        schedule(0);
        zero_from(9, 12);
        st_v[14] = 1;
        schedule(14);
        check("pin_rst_done_at", done_at, 33);
        run(40);

        // Start in the done cycle is ignored, one cycle later it is taken
        clear_model();
        st_v[0] = 1; st_v[19] = 1; st_v[20] = 1;
        schedule(0);
        schedule(20);
        check("pin_b2b_rd21", e_rd[21], 1);
        check("pin_b2b_rd20", e_rd[20], 0);
        run(44);

`ifdef NTT_AGEN_HOLD_EN
        // Hold for two RUN cycles
        clear_model();
        st_v[0] = 1; hold_v[2] = 1; hold_v[3] = 1;
        schedule(0);
        check("pin_hold_done_at", done_at, 21);
        check("pin_hold_wr3", e_wr[3], 1);
        check("pin_hold_a0_4", e_a0[4], 2);
        check("pin_hold_rd2", e_rd[2], 0);
        run(26);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
